// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer and its channels.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StWaitHi   = 2'd1,
    StStableHi = 2'd2,
    StWaitLo   = 2'd3
  } chan_state_e;

  localparam int unsigned DefaultDebounceCnt = 120000;
  localparam int unsigned CntWidth           = 32;

endpackage

// File: rtl/switch_debouncer_if.sv
// Bundles the raw switch pins and the debounced outputs of switch_debouncer.
interface switch_debouncer_if;
  logic sw1_raw;
  logic sw2_raw;
  logic btn_raw;
  logic sw1;
  logic sw2;
  logic en;
  logic sel_change;

  modport master (
    output sw1_raw, sw2_raw, btn_raw,
    input  sw1, sw2, en, sel_change
  );

  modport slave (
    input  sw1_raw, sw2_raw, btn_raw,
    output sw1, sw2, en, sel_change
  );
endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, 4-state FSM and stability counter.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DebounceCnt = DefaultDebounceCnt
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCnt - 1);

  logic                sync1_q, sync2_q;
  chan_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StStableLo;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStableLo: begin
        if (sync2_q) begin
          state_d = StWaitHi;
          cnt_d   = '0;
        end
      end
      StWaitHi: begin
        // A bounce drops back to the stable state and discards the partial count.
        if (!sync2_q) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStableHi: begin
        if (!sync2_q) begin
          state_d = StWaitLo;
          cnt_d   = '0;
        end
      end
      StWaitLo: begin
        if (sync2_q) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = (state_q == StStableHi) || (state_q == StWaitLo);

endmodule

// File: rtl/switch_debouncer.sv
// Debounces two frequency-select switches and an enable button; drives the blinker's
// SW1/SW2/EN inputs and flags any select change with a one-cycle pulse.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned C_DEBOUNCE_CNT = DefaultDebounceCnt
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW1_RAW,
  input  logic SW2_RAW,
  input  logic BTN_RAW,
  output logic SW1,
  output logic SW2,
  output logic EN,
  output logic SEL_CHANGE
);

  logic sw1_lvl, sw2_lvl, btn_lvl;
  logic sw1_prev_q, sw1_prev_d;
  logic sw2_prev_q, sw2_prev_d;
  logic btn_prev_q, btn_prev_d;
  logic en_q, en_d;
  logic sel_q, sel_d;

  debounce_channel #(.DebounceCnt(C_DEBOUNCE_CNT)) u_sw1 (
    .clk_i   (CLK),
    .rst_i   (RST),
    .raw_i   (SW1_RAW),
    .level_o (sw1_lvl)
  );

  debounce_channel #(.DebounceCnt(C_DEBOUNCE_CNT)) u_sw2 (
    .clk_i   (CLK),
    .rst_i   (RST),
    .raw_i   (SW2_RAW),
    .level_o (sw2_lvl)
  );

  debounce_channel #(.DebounceCnt(C_DEBOUNCE_CNT)) u_btn (
    .clk_i   (CLK),
    .rst_i   (RST),
    .raw_i   (BTN_RAW),
    .level_o (btn_lvl)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw1_prev_q <= 1'b0;
      sw2_prev_q <= 1'b0;
      btn_prev_q <= 1'b0;
      en_q       <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      sw1_prev_q <= sw1_prev_d;
      sw2_prev_q <= sw2_prev_d;
      btn_prev_q <= btn_prev_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
    end
  end

  always_comb begin
    sw1_prev_d = sw1_lvl;
    sw2_prev_d = sw2_lvl;
    btn_prev_d = btn_lvl;
    // Only a debounced rising level counts as a press; a WAIT_LO glitch never toggles.
    en_d       = en_q ^ (btn_lvl & ~btn_prev_q);
    sel_d      = (sw1_lvl ^ sw1_prev_q) | (sw2_lvl ^ sw2_prev_q);
  end

  assign SW1        = sw1_lvl;
  assign SW2        = sw2_lvl;
  assign EN         = en_q;
  assign SEL_CHANGE = sel_q;

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter C_DEBOUNCE_CNT, default 120000, meaning the number of consecutive stable clock samples required to accept a new level (10 ms at 12 MHz).
REQ-002 SHALL have port CLK, input, 1 bit: the 12 MHz system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port SW1_RAW, input, 1 bit: raw, asynchronous pin for frequency-select switch 1.
REQ-005 SHALL have port SW2_RAW, input, 1 bit: raw, asynchronous pin for frequency-select switch 2.
REQ-006 SHALL have port BTN_RAW, input, 1 bit: raw, asynchronous enable push-button (high = pressed).
REQ-007 SHALL have port SW1, output, 1 bit: debounced level of SW1_RAW.
REQ-008 SHALL have port SW2, output, 1 bit: debounced level of SW2_RAW.
REQ-009 SHALL have port EN, output, 1 bit: enable latch that toggles on each debounced press of BTN_RAW.
REQ-010 SHALL have port SEL_CHANGE, output, 1 bit: one-cycle pulse whenever debounced SW1 or SW2 changes.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer before any other logic; no raw input reaches any other logic.
REQ-012 Each channel SHALL implement a 4-state FSM:
- STABLE_LO -> WAIT_HI when the synchronized input is 1.
- WAIT_HI -> STABLE_HI once the count reaches C_DEBOUNCE_CNT-1 while the input is still 1.
- WAIT_HI -> STABLE_LO when the input returns to 0.
- STABLE_HI, WAIT_LO: mirror image of the above.
REQ-013 The per-channel counter SHALL:
- increment each cycle in a WAIT_* state;
- clear to 0 on every state transition;
- be 32 bits wide and never wrap.
REQ-014 The debounced output SHALL equal 1 exactly in STABLE_HI and WAIT_LO.
REQ-015 A clean input edge SHALL appear on the debounced output exactly 2 + C_DEBOUNCE_CNT rising edges after the first edge that samples the new raw level.
REQ-016 A glitch held for fewer than C_DEBOUNCE_CNT synchronized cycles SHALL leave the output unchanged and return the FSM to its prior stable state.
REQ-017 Timing SHALL restart on each bounce: a bounce during WAIT_* restarts timing from zero on the next attempt; partial counts are not retained.
REQ-018 EN SHALL toggle in the cycle after the button channel enters STABLE_HI; release (entering STABLE_LO) SHALL NOT affect EN.
REQ-019 SEL_CHANGE SHALL be high for exactly one cycle, in the cycle after SW1 or SW2 changes.
- If SW1 and SW2 change in the same cycle, it SHALL pulse exactly once.
- Changes in different cycles SHALL produce separate pulses.
REQ-020 The three channels SHALL be independent; simultaneous activity on all inputs SHALL NOT alter any channel's timing.
REQ-021 C_DEBOUNCE_CNT = 1 SHALL be legal: the output then follows the synchronized input with one extra cycle of delay.

Reset
REQ-022 While RST is high, the block SHALL hold:
- synchronizer flops = 0;
- all FSMs = STABLE_LO;
- counters = 0;
- SW1 = SW2 = EN = SEL_CHANGE = 0.
REQ-023 Reset SHALL take effect immediately, independent of CLK, including mid-WAIT; no pending transition survives it.
REQ-024 After RST deasserts, inputs already held high SHALL be debounced normally (full 2 + C latency).
REQ-025 An input held high at reset release SHALL NOT produce an EN toggle or SEL_CHANGE pulse earlier than that 2 + C latency.

Structure
REQ-026 A shared package SHALL hold:
- the channel state enumeration (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO);
- the default debounce constant (120000);
- the 32-bit counter width constant.
REQ-027 Channel logic (synchronizer, FSM, counter) SHALL be one sub-module, debounce_channel, instantiated three times.
REQ-028 The EN toggle and SEL_CHANGE logic SHALL reside in switch_debouncer.
REQ-029 switch_debouncer outputs SHALL drive the LED blinker's SW1/SW2/EN inputs directly.

Verification (C_DEBOUNCE_CNT = 4)
REQ-030 Reset / clean rise: RST pulse, then SW1_RAW 0->1 held -> SW1 rises exactly 6 edges later; SW2, EN, SEL_CHANGE remain 0; SEL_CHANGE pulses 1 cycle after SW1 rises.
REQ-031 Bounce: SW1_RAW toggles 1,0,1,0,1 with 2-cycle widths, then held 1 -> SW1 stays 0 during the bounce and rises 6 edges after the final rising edge.
REQ-032 Button: BTN_RAW high for 10 cycles, low for 10 cycles, repeated twice -> EN goes 1, then 0, toggling once per press; a 3-cycle BTN_RAW pulse causes no toggle.
REQ-033 Simultaneous change: SW1_RAW and SW2_RAW rise on the same edge -> both outputs rise on the same edge; SEL_CHANGE is a single 1-cycle pulse.
REQ-034 Reset mid-operation: assert RST asynchronously (between CLK edges) 2 cycles into WAIT_HI -> all outputs 0 immediately; after release with the input still high, the output rises 6 edges later.
